// File: rtl/fpu_norm_round_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_norm_round_seq_pkg
// Brief  : Shared types and constants for the FP32 normaliser/rounder.
// Rev    : 1.0  initial release
// ============================================================================
package fpu_norm_round_seq_pkg;

  // FSM states of the normaliser/rounder
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam int          EXP_BIAS  = 127;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // Signed zero (used for flush-to-zero results)
  function automatic logic [31:0] fp32_zero(input logic sign);
    return {sign, 31'b0};
  endfunction

  // Signed infinity (used for overflow results)
  function automatic logic [31:0] fp32_inf(input logic sign);
    return {sign, EXP_MAX, 23'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_norm_round_seq_round_rne.sv
`default_nettype none
// ============================================================================
// Module : fpu_norm_round_seq_round_rne
// Brief  : Combinational round-to-nearest-even on a normalised significand
//          hidden.frac.G.R.S; reports the rounding carry and inexact.
// Rev    : 1.0  initial release
// ============================================================================
module fpu_norm_round_seq_round_rne #(
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W+3:0] mant,
  output logic [FRAC_W-1:0] frac,
  output logic              carry,
  output logic              inexact
);

  logic              guard_b;
  logic              round_b;
  logic              sticky_b;
  logic              lsb_b;
  logic              round_up;
  logic [FRAC_W+1:0] sum;

  // Round up on more than half, or exactly half with an odd lsb; renormalise on carry
  always_comb begin
    guard_b  = mant[2];
    round_b  = mant[1];
    sticky_b = mant[0];
    lsb_b    = mant[3];
    round_up = guard_b & (round_b | sticky_b | lsb_b);
    sum      = {1'b0, mant[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, round_up};
    carry    = sum[FRAC_W+1];
    frac     = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    inexact  = guard_b | round_b | sticky_b;
  end

endmodule
`default_nettype wire

// File: rtl/fpu_norm_round_seq.sv
`default_nettype none
// ============================================================================
// Module : fpu_norm_round_seq
// Brief  : Multi-cycle FP32 normaliser (one bit per cycle) and RNE rounder
//          with flush-to-zero packing and valid/ready handshakes.
// Rev    : 1.0  initial release
// ============================================================================
module fpu_norm_round_seq
  import fpu_norm_round_seq_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRAC_W+3:0]       mant_res,
  input  logic                    carry_out,
  input  logic [EXP_W-1:0]        exp_big,
  input  logic                    sign_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    flag_ovf,
  output logic                    flag_unf,
  output logic                    flag_inx
);

  localparam int SIG_W = FRAC_W + 4;
  localparam int XW    = EXP_W + 2;
  localparam int RES_W = EXP_W + FRAC_W + 1;

  // Exponent values are held signed with two guard bits so underflow/overflow are visible
  localparam logic signed [XW-1:0] EXP_TOP = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [SIG_W-1:0]         mant_q, mant_d;
  logic signed [XW-1:0]     exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic [RES_W-1:0]         result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     inx_q, inx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic [FRAC_W-1:0]        rnd_frac;
  logic                     rnd_carry;
  logic                     rnd_inexact;
  logic [SIG_W-1:0]         mant_shl;
  logic signed [XW-1:0]     exp_rnd;

  fpu_norm_round_seq_round_rne #(
    .FRAC_W (FRAC_W)
  ) u_round (
    .mant    (mant_q),
    .frac    (rnd_frac),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  // Next-state and datapath computation for capture, normalise, round and hand-off
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    mant_shl    = {mant_q[SIG_W-2:0], 1'b0};
    exp_rnd     = exp_q + $signed({{(XW-1){1'b0}}, rnd_carry});

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          sign_d     = sign_res;
          if (carry_out) begin
            // Significand is 1x.xxx: shift right, keep the dropped bit sticky
            mant_d  = {1'b1, mant_res[SIG_W-1:2], mant_res[1] | mant_res[0]};
            exp_d   = $signed({2'b00, exp_big}) + EXP_ONE;
            state_d = ST_ROUND;
          end else if (mant_res == '0) begin
            // Exact cancellation gives +0 under RNE regardless of operand signs
            result_d    = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            inx_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            mant_d  = mant_res;
            exp_d   = $signed({2'b00, exp_big});
            state_d = mant_res[SIG_W-1] ? ST_ROUND : ST_NORM;
          end
        end
      end

      ST_NORM: begin
        if (exp_q <= EXP_ONE) begin
          // Result would be subnormal: flush to signed zero
          result_d    = {sign_q, {(RES_W-1){1'b0}}};
          ovf_d       = 1'b0;
          unf_d       = 1'b1;
          inx_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          mant_d = mant_shl;
          exp_d  = exp_q - EXP_ONE;
          if (mant_shl[SIG_W-1]) begin
            state_d = ST_ROUND;
          end
        end
      end

      ST_ROUND: begin
        unf_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
        if (exp_rnd >= EXP_TOP) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
          inx_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[EXP_W-1:0], rnd_frac};
          ovf_d    = 1'b0;
          inx_d    = rnd_inexact;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons any operand in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_inx  = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_norm_round_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_fpu_norm_round_seq
// Brief  : Directed self-checking bench for fpu_norm_round_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fpu_norm_round_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] mant_res;
  logic        carry_out;
  logic [7:0]  exp_big;
  logic        sign_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_norm_round_seq #(
    .EXP_W  (8),
    .FRAC_W (23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_res  (mant_res),
    .carry_out (carry_out),
    .exp_big   (exp_big),
    .sign_res  (sign_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx)
  );

  // Present one operand, accept it, and count cycles until out_valid (-1 on timeout)
  task automatic do_op(input logic [26:0] m, input logic c, input logic [7:0] e,
                       input logic s, output int lat);
    @(negedge clk);
    mant_res  = m;
    carry_out = c;
    exp_big   = e;
    sign_res  = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = i;
    end
  endtask

  // Take the pending result (one cycle of out_ready)
  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h f=%b%b%b", in_ready, out_valid, result,
               flag_ovf, flag_unf, flag_inx);
    end
  endtask

  task automatic test_carry();
    int lat;
    do_op(27'h0000000, 1'b1, 8'd127, 1'b0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL carry_latency got %0d exp 2", lat); end
    checks++;
    if ({result, flag_ovf, flag_unf, flag_inx} !== {32'h4000_0000, 3'b000}) begin
      errors++;
      $display("FAIL carry_1p1 got %h/%b%b%b exp 40000000/000", result, flag_ovf, flag_unf, flag_inx);
    end
    consume();
  endtask

  task automatic test_norm();
    logic [26:0] m  [2] = '{27'h1000000, 27'h0000001};
    int          el [2] = '{4, 28};
    logic [31:0] er [2] = '{32'h3E80_0000, 32'h3280_0000};
    int lat;
    for (int k = 0; k < 2; k++) begin
      do_op(m[k], 1'b0, 8'd127, 1'b0, lat);
      checks++;
      if (lat !== el[k]) begin errors++; $display("FAIL norm_latency[%0d] got %0d exp %0d", k, lat, el[k]); end
      checks++;
      if ({result, flag_ovf, flag_unf, flag_inx} !== {er[k], 3'b000}) begin
        errors++;
        $display("FAIL norm_result[%0d] got %h/%b%b%b exp %h/000", k, result, flag_ovf, flag_unf, flag_inx, er[k]);
      end
      consume();
    end
  endtask

  task automatic test_cancel();
    int lat;
    do_op(27'h0000000, 1'b0, 8'd127, 1'b1, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL cancel_latency got %0d exp 1", lat); end
    checks++;
    if ({result, flag_ovf, flag_unf, flag_inx} !== {32'h0000_0000, 3'b000}) begin
      errors++;
      $display("FAIL cancel_result got %h/%b%b%b exp 00000000/000", result, flag_ovf, flag_unf, flag_inx);
    end
    consume();
  endtask

  task automatic test_rne();
    logic [26:0] m  [3] = '{27'h400000C, 27'h4000004, 27'h7FFFFFF};
    logic [31:0] er [3] = '{32'h3F80_0002, 32'h3F80_0000, 32'h4000_0000};
    int lat;
    for (int k = 0; k < 3; k++) begin
      do_op(m[k], 1'b0, 8'd127, 1'b0, lat);
      checks++;
      if ({lat, result, flag_ovf, flag_unf, flag_inx} !== {32'd2, er[k], 3'b001}) begin
        errors++;
        $display("FAIL rne[%0d] got lat=%0d %h/%b%b%b exp lat=2 %h/001", k, lat, result,
                 flag_ovf, flag_unf, flag_inx, er[k]);
      end
      consume();
    end
  endtask

  task automatic test_overflow();
    logic        s  [2] = '{1'b0, 1'b1};
    logic [31:0] er [2] = '{32'h7F80_0000, 32'hFF80_0000};
    int lat;
    for (int k = 0; k < 2; k++) begin
      do_op(27'h0000000, 1'b1, 8'd254, s[k], lat);
      checks++;
      if ({lat, result, flag_ovf, flag_unf, flag_inx} !== {32'd2, er[k], 3'b101}) begin
        errors++;
        $display("FAIL overflow[%0d] got lat=%0d %h/%b%b%b exp lat=2 %h/101", k, lat, result,
                 flag_ovf, flag_unf, flag_inx, er[k]);
      end
      consume();
    end
  endtask

  task automatic test_underflow();
    logic        s  [2] = '{1'b0, 1'b1};
    logic [31:0] er [2] = '{32'h0000_0000, 32'h8000_0000};
    int lat;
    for (int k = 0; k < 2; k++) begin
      do_op(27'h2000000, 1'b0, 8'd1, s[k], lat);
      checks++;
      if ({lat, result, flag_ovf, flag_unf, flag_inx} !== {32'd2, er[k], 3'b011}) begin
        errors++;
        $display("FAIL underflow[%0d] got lat=%0d %h/%b%b%b exp lat=2 %h/011", k, lat, result,
                 flag_ovf, flag_unf, flag_inx, er[k]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(27'h0000000, 1'b1, 8'd127, 1'b0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", lat); end
    // A competing operand must not be taken while the result is held
    mant_res  = 27'h0000000;
    carry_out = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h4000_0000}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b res=%h exp vld=1 rdy=0 res=40000000", i,
                 out_valid, in_ready, result);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    @(negedge clk);
    mant_res  = 27'h0000001;
    carry_out = 1'b0;
    exp_big   = 8'd127;
    sign_res  = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL rst_mid_op got rdy=%b vld=%b res=%h f=%b%b%b exp rdy=1 vld=0 res=0 f=000",
               in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_dropped got %0d valid cycles exp 0", seen); end
    do_op(27'h0000000, 1'b1, 8'd127, 1'b0, lat);
    checks++;
    if ({lat, result} !== {32'd2, 32'h4000_0000}) begin
      errors++;
      $display("FAIL rst_recover got lat=%0d res=%h exp lat=2 res=40000000", lat, result);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int rdy_cnt;
    int vld_cnt;
    int bad;
    mant_res  = 27'h0000000;
    carry_out = 1'b1;
    exp_big   = 8'd127;
    sign_res  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    rdy_cnt = 0;
    vld_cnt = 0;
    bad     = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready === 1'b1) rdy_cnt++;
      if (out_valid === 1'b1) begin
        vld_cnt++;
        if (result !== 32'h4000_0000) bad++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({rdy_cnt, vld_cnt, bad} !== {32'd4, 32'd4, 32'd0}) begin
      errors++;
      $display("FAIL back_to_back got accepts=%0d outputs=%0d badres=%0d exp 4 4 0", rdy_cnt, vld_cnt, bad);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_res  = '0;
    carry_out = 1'b0;
    exp_big   = '0;
    sign_res  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_carry();
    test_norm();
    test_cancel();
    test_rne();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
